ra_pq_param: RTL and testbench
==============================

Name: ra_pq_param

Overview:
- Parametrised register-array priority queue; successor to the fixed-size ra_pq used under the pq_if harness.
- Holds up to DEPTH (key, value) pairs kept sorted in a register array; slot 0 is always the head.
- Adds configurable key/value widths, a min/max ordering mode, a single-cycle replace operation, occupancy count, and sticky error flags.
- Sits behind the same enq/deq style front end as the existing PQ study blocks; driven directly by the bench or an arbiter.

Parameters:
- KEY_W, 8, key (priority) width in bits.
- VAL_W, 8, payload width in bits.
- DEPTH, 8, number of slots; must be ≥ 2.
- MAX_FIRST, 0, ordering: 0 = smallest key at head, 1 = largest key at head.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enq  in  1  enqueue request.
- kin  in  KEY_W  key to enqueue.
- vin  in  VAL_W  value to enqueue.
- deq  in  1  dequeue request; removes the head.
- kout  out  KEY_W  head key (slot 0).
- vout  out  VAL_W  head value (slot 0).
- valid  out  1  head slot occupied (equals !empty).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH+1)  current occupancy.
- ovf  out  1  sticky: enq attempted while full.
- unf  out  1  sticky: deq attempted while empty.
- clr_err  in  1  synchronous clear of ovf/unf.

Behaviour:
- Reset (async, rst_n low):
  - All slot keys, values and occupied bits go to 0.
  - count = 0, empty = 1, full = 0, valid = 0, kout = 0, vout = 0, ovf = 0, unf = 0.
  - Any operation in flight is discarded.
- Storage: slots 0..DEPTH-1 each hold key, value and an occupied bit. Occupied slots are contiguous from 0.
- Ordering: "better" means key < other key (MAX_FIRST = 0) or key > other key (MAX_FIRST = 1). Compares are unsigned, KEY_W bits.
- Ties are FIFO: a new key is inserted after all existing equal keys.
- Head outputs come directly from registers (no combinational path from inputs). Every operation takes effect at the clock edge; the new head is visible the cycle after the request. Throughput is one operation per cycle.
- Operations, decoded from {enq, deq} each cycle:
  - 00 idle: state held.
  - 10 enqueue:
    - If not full: new entry goes to the first slot i whose occupant is unoccupied or strictly worse than kin. Slots i..DEPTH-2 shift down by one. count += 1.
    - If full: no change, ovf set.
  - 01 dequeue:
    - If not empty: all slots shift up by one; the last slot clears. count -= 1.
    - If empty: no change, unf set.
  - 11 replace:
    - If not empty: the head is removed and kin/vin inserted in the same cycle; count unchanged. Legal when full. The insert position is computed over slots 1..DEPTH-1, and ties are FIFO.
    - If empty: behaves as a plain enqueue of kin/vin; count becomes 1; unf not set.
- Flags:
  - ovf/unf stay set until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the flag ends up set.
- full, empty, valid and count are registered and consistent with the slot state every cycle.
- Inputs are sampled only when enq/deq is high; kin/vin are ignored otherwise.

Optional Feature:
- Macro: RA_PQ_HWM_EN.
- Defined:
  - Adds output hwm [$clog2(DEPTH+1)-1:0], the high-water mark of count since the last reset or clr_err.
  - Reset value 0. Updates the cycle after count exceeds it.
  - On clr_err, hwm loads the current count.
- Not defined: no hwm port and no extra logic; port list exactly as above.

Test Plan:
- Ordered fill, MAX_FIRST = 0, DEPTH = 4: enqueue keys 5, 2, 9, 2 (values A, B, C, D), then dequeue 4 times.
  - Required output order is (2,B), (2,D), (5,A), (9,C), which checks FIFO tie ordering.
  - count goes 1, 2, 3, 4, then 3, 2, 1, 0; full is high only at count 4.
- Overflow: with a full DEPTH = 4 queue, enq key 0 → contents unchanged, ovf = 1, count = 4. Then clr_err → ovf = 0.
- Underflow: deq on an empty queue → unf = 1, count = 0, valid = 0. Then enq+deq with key 7 → count = 1, head = 7, unf unchanged.
- Replace at full: queue holds {1, 3, 5, 7}; enq+deq with key 4 → contents {3, 4, 5, 7}, count = 4, no ovf. Replace with key 0 → head = 0.
- MAX_FIRST = 1: enqueue 3, 8, 1 → head 8, then dequeue order 8, 3, 1.
- Async reset mid-operation: assert rst_n low between clock edges with count = 3.
  - All outputs reach reset values immediately, without waiting for a clock edge.
  - After release, the first enq of key 6 gives count = 1, head = 6.
  - With RA_PQ_HWM_EN defined, hwm = 0 after reset.

Source files
------------

// File: rtl/ra_pq_param.sv
// Parametrised register-array priority queue: sorted slots with slot 0 as the head,
// min/max ordering, single-cycle replace, and sticky ovf/unf flags. Optional RA_PQ_HWM_EN adds an hwm output.
module ra_pq_param #(
    parameter int KEY_W     = 8,
    parameter int VAL_W     = 8,
    parameter int DEPTH     = 8,
    parameter int MAX_FIRST = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enq,
    input  logic [KEY_W-1:0]           kin,
    input  logic [VAL_W-1:0]           vin,
    input  logic                       deq,
    input  logic                       clr_err,
    output logic [KEY_W-1:0]           kout,
    output logic [VAL_W-1:0]           vout,
    output logic                       valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf,
    output logic                       unf
`ifdef RA_PQ_HWM_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] hwm
`endif
);

    localparam int CW = $clog2(DEPTH+1);

    logic [KEY_W-1:0] key_q [DEPTH];
    logic [KEY_W-1:0] key_d [DEPTH];
    logic [VAL_W-1:0] val_q [DEPTH];
    logic [VAL_W-1:0] val_d [DEPTH];
    logic [DEPTH-1:0] occ_q, occ_d;
    logic [KEY_W-1:0] b_key [DEPTH];
    logic [VAL_W-1:0] b_val [DEPTH];
    logic [DEPTH-1:0] b_occ;
    logic [DEPTH-1:0] go;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q, valid_q;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             do_shift, do_ins, seen;

    // Equal keys are never "worse", so a new key lands after all its ties.
    function automatic logic worse(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
        return (MAX_FIRST != 0) ? (a < b) : (a > b);
    endfunction

    always_comb begin
        do_shift = deq && !empty_q;
        do_ins   = enq && (!full_q || do_shift);

        // Base array: the current slots, moved up by one when the head leaves.
        for (int i = 0; i < DEPTH-1; i++) begin
            b_key[i] = do_shift ? key_q[i+1] : key_q[i];
            b_val[i] = do_shift ? val_q[i+1] : val_q[i];
            b_occ[i] = do_shift ? occ_q[i+1] : occ_q[i];
        end
        b_key[DEPTH-1] = do_shift ? '0   : key_q[DEPTH-1];
        b_val[DEPTH-1] = do_shift ? '0   : val_q[DEPTH-1];
        b_occ[DEPTH-1] = do_shift ? 1'b0 : occ_q[DEPTH-1];

        for (int j = 0; j < DEPTH; j++) begin
            go[j] = !b_occ[j] || worse(b_key[j], kin);
        end

        seen     = do_ins && go[0];
        key_d[0] = seen ? kin  : b_key[0];
        val_d[0] = seen ? vin  : b_val[0];
        occ_d[0] = seen ? 1'b1 : b_occ[0];
        for (int j = 1; j < DEPTH; j++) begin
            if (seen) begin
                key_d[j] = b_key[j-1];
                val_d[j] = b_val[j-1];
                occ_d[j] = b_occ[j-1];
            end else if (do_ins && go[j]) begin
                key_d[j] = kin;
                val_d[j] = vin;
                occ_d[j] = 1'b1;
            end else begin
                key_d[j] = b_key[j];
                val_d[j] = b_val[j];
                occ_d[j] = b_occ[j];
            end
            seen = seen || (do_ins && go[j]);
        end

        count_d = count_q + CW'(do_ins) - CW'(do_shift);
        ovf_d   = (ovf_q && !clr_err) || (enq && !deq && full_q);
        unf_d   = (unf_q && !clr_err) || (deq && !enq && empty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= '0;
                val_q[i] <= '0;
            end
            occ_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= key_d[i];
                val_q[i] <= val_d[i];
            end
            occ_q   <= occ_d;
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
            valid_q <= (count_d != '0);
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef RA_PQ_HWM_EN
    logic [CW-1:0] hwm_q;

    // Tracks the registered count, so a new peak shows up one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q <= '0;
        end else if (clr_err) begin
            hwm_q <= count_q;
        end else if (count_q > hwm_q) begin
            hwm_q <= count_q;
        end
    end

    assign hwm = hwm_q;
`endif

    assign kout  = key_q[0];
    assign vout  = val_q[0];
    assign valid = valid_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_ra_pq_param.sv
// Bench for ra_pq_param: min-first and max-first instances (DEPTH=4) driven in lockstep
// and compared against a queue-based reference model, plus directed vectors and corner sequences.
module tb_ra_pq_param;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enq = 1'b0, deq = 1'b0, clr_err = 1'b0;
  logic [7:0]    kin = '0, vin = '0;
  logic [7:0]    kout0, vout0, kout1, vout1;
  logic          valid0, full0, empty0, ovf0, unf0;
  logic          valid1, full1, empty1, ovf1, unf1;
  logic [CW-1:0] count0, count1;
`ifdef RA_PQ_HWM_EN
  logic [CW-1:0] hwm0, hwm1;
`endif

  always #5 clk = ~clk;

  ra_pq_param #(.KEY_W(8), .VAL_W(8), .DEPTH(DEPTH), .MAX_FIRST(0)) dut (
    .clk(clk), .rst_n(rst_n), .enq(enq), .kin(kin), .vin(vin), .deq(deq), .clr_err(clr_err),
    .kout(kout0), .vout(vout0), .valid(valid0), .full(full0), .empty(empty0), .count(count0),
    .ovf(ovf0), .unf(unf0)
`ifdef RA_PQ_HWM_EN
    , .hwm(hwm0)
`endif
  );

  ra_pq_param #(.KEY_W(8), .VAL_W(8), .DEPTH(DEPTH), .MAX_FIRST(1)) dut_max (
    .clk(clk), .rst_n(rst_n), .enq(enq), .kin(kin), .vin(vin), .deq(deq), .clr_err(clr_err),
    .kout(kout1), .vout(vout1), .valid(valid1), .full(full1), .empty(empty1), .count(count1),
    .ovf(ovf1), .unf(unf1)
`ifdef RA_PQ_HWM_EN
    , .hwm(hwm1)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] k;
    logic [7:0] v;
  } ent_t;

  ent_t mq0[$];
  ent_t mq1[$];
  logic m_ovf = 1'b0, m_unf = 1'b0;
  int   m_hwm = 0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int find_pos(input bit maxf, input logic [7:0] k);
    int n;
    n = maxf ? mq1.size() : mq0.size();
    for (int i = 0; i < n; i++) begin
      logic [7:0] ek;
      ek = maxf ? mq1[i].k : mq0[i].k;
      if (maxf ? (ek < k) : (ek > k)) return i;
    end
    return n;
  endfunction

  task automatic model_insert(input logic [7:0] k, input logic [7:0] v);
    ent_t e;
    int p0, p1;
    e.k = k;
    e.v = v;
    p0 = find_pos(1'b0, k);
    p1 = find_pos(1'b1, k);
    mq0.insert(p0, e);
    mq1.insert(p1, e);
  endtask

  task automatic model_step(input logic e, input logic d, input logic c,
                            input logic [7:0] k, input logic [7:0] v);
    int  n;
    bit  o_set, u_set;
    n = mq0.size();
    o_set = 0;
    u_set = 0;
    if (e && d) begin
      if (n > 0) begin
        void'(mq0.pop_front());
        void'(mq1.pop_front());
      end
      model_insert(k, v);
    end else if (e) begin
      if (n == DEPTH) o_set = 1;
      else model_insert(k, v);
    end else if (d) begin
      if (n == 0) u_set = 1;
      else begin
        void'(mq0.pop_front());
        void'(mq1.pop_front());
      end
    end
    m_ovf = (m_ovf && !c) || o_set;
    m_unf = (m_unf && !c) || u_set;
    if (c) m_hwm = n;
    else if (n > m_hwm) m_hwm = n;
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_hwm = 0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] ek0, ev0, ek1, ev1;
    int n;
    n   = mq0.size();
    ek0 = (n > 0) ? mq0[0].k : 8'h00;
    ev0 = (n > 0) ? mq0[0].v : 8'h00;
    ek1 = (n > 0) ? mq1[0].k : 8'h00;
    ev1 = (n > 0) ? mq1[0].v : 8'h00;
    chk({tag, " kout_min"}, 32'(kout0), 32'(ek0));
    chk({tag, " vout_min"}, 32'(vout0), 32'(ev0));
    chk({tag, " kout_max"}, 32'(kout1), 32'(ek1));
    chk({tag, " vout_max"}, 32'(vout1), 32'(ev1));
    chk({tag, " count"}, 32'(count0), 32'(n));
    chk({tag, " count_max"}, 32'(count1), 32'(n));
    chk({tag, " flags_min"}, {27'b0, valid0, full0, empty0, ovf0, unf0},
        {27'b0, n != 0, n == DEPTH, n == 0, m_ovf, m_unf});
    chk({tag, " flags_max"}, {27'b0, valid1, full1, empty1, ovf1, unf1},
        {27'b0, n != 0, n == DEPTH, n == 0, m_ovf, m_unf});
`ifdef RA_PQ_HWM_EN
    chk({tag, " hwm_min"}, 32'(hwm0), 32'(m_hwm));
    chk({tag, " hwm_max"}, 32'(hwm1), 32'(m_hwm));
`endif
  endtask

  // One clocked operation: drive at negedge, sample 1ns after the rising edge.
  task automatic op(input logic e, input logic d, input logic c,
                    input logic [7:0] k, input logic [7:0] v, input string tag);
    @(negedge clk);
    enq = e; deq = d; clr_err = c; kin = k; vin = v;
    @(posedge clk);
    #1;
    enq = 1'b0; deq = 1'b0; clr_err = 1'b0;
    kin = $urandom_range(0, 255);
    vin = $urandom_range(0, 255);
    model_step(e, d, c, k, v);
    check_all(tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       e, d, c;
    logic [7:0] k, v;
    logic [7:0] ek, ev;
    int         ecnt;
    logic       efull, eovf, eunf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic d, input logic c,
                              input logic [7:0] k, input logic [7:0] v,
                              input logic [7:0] ek, input logic [7:0] ev, input int ecnt,
                              input logic efull, input logic eovf, input logic eunf);
    vec_t r;
    r.e = e; r.d = d; r.c = c; r.k = k; r.v = v;
    r.ek = ek; r.ev = ev; r.ecnt = ecnt; r.efull = efull; r.eovf = eovf; r.eunf = eunf;
    return r;
  endfunction

  initial begin
    // Ordered fill with FIFO ties, then drain.
    vecs.push_back(mk(1, 0, 0, 8'd5, 8'hA1, 8'd5, 8'hA1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'd2, 8'hB2, 8'd2, 8'hB2, 2, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'd9, 8'hC3, 8'd2, 8'hB2, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'd2, 8'hD4, 8'd2, 8'hB2, 4, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'd0, 8'h00, 8'd2, 8'hD4, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'd0, 8'h00, 8'd5, 8'hA1, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'd0, 8'h00, 8'd9, 8'hC3, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'd0, 8'h00, 8'd0, 8'h00, 0, 0, 0, 0));
    // Fill {1,3,5,7}, overflow, clear.
    vecs.push_back(mk(1, 0, 0, 8'd1, 8'h11, 8'd1, 8'h11, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'd7, 8'h17, 8'd1, 8'h11, 2, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'd3, 8'h13, 8'd1, 8'h11, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'd5, 8'h15, 8'd1, 8'h11, 4, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'd0, 8'h10, 8'd1, 8'h11, 4, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'd0, 8'h00, 8'd1, 8'h11, 4, 1, 0, 0));
    // Replace at full: {3,4,5,7}, then replace with 0 -> {0,4,5,7}, drain.
    vecs.push_back(mk(1, 1, 0, 8'd4, 8'h14, 8'd3, 8'h13, 4, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'd0, 8'h10, 8'd0, 8'h10, 4, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'd0, 8'h00, 8'd4, 8'h14, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'd0, 8'h00, 8'd5, 8'h15, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'd0, 8'h00, 8'd7, 8'h17, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'd0, 8'h00, 8'd0, 8'h00, 0, 0, 0, 0));
    // Underflow, then replace on empty acts as enqueue, unf held until clear.
    vecs.push_back(mk(0, 1, 0, 8'd0, 8'h00, 8'd0, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 8'd7, 8'h27, 8'd7, 8'h27, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'd0, 8'h00, 8'd7, 8'h27, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'd0, 8'h00, 8'd0, 8'h00, 0, 0, 0, 0));
  end

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    #23;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      op(vecs[i].e, vecs[i].d, vecs[i].c, vecs[i].k, vecs[i].v, t);
      chk({t, " tbl_kout"}, 32'(kout0), 32'(vecs[i].ek));
      chk({t, " tbl_vout"}, 32'(vout0), 32'(vecs[i].ev));
      chk({t, " tbl_count"}, 32'(count0), 32'(vecs[i].ecnt));
      chk({t, " tbl_flags"}, {29'b0, full0, ovf0, unf0},
          {29'b0, vecs[i].efull, vecs[i].eovf, vecs[i].eunf});
    end

    // Max-first ordering: enqueue 3, 8, 1; drain order 8, 3, 1.
    op(1, 0, 0, 8'd3, 8'h33, "maxf_e3");
    op(1, 0, 0, 8'd8, 8'h38, "maxf_e8");
    op(1, 0, 0, 8'd1, 8'h31, "maxf_e1");
    chk("maxf head", 32'(kout1), 32'd8);
    chk("minf head", 32'(kout0), 32'd1);
    op(0, 1, 0, 8'd0, 8'h00, "maxf_d1");
    chk("maxf second", 32'(kout1), 32'd3);
    op(0, 1, 0, 8'd0, 8'h00, "maxf_d2");
    chk("maxf third", 32'(kout1), 32'd1);
    op(0, 1, 0, 8'd0, 8'h00, "maxf_d3");
    chk("maxf empty", {31'b0, empty1}, 32'd1);

    // Randomized traffic with a small key range to force ties.
    for (int i = 0; i < 400; i++) begin
      logic e, d, c;
      e = ($urandom_range(0, 99) < 55);
      d = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 15) == 0);
      op(e, d, c, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), $sformatf("rnd%0d", i));
    end

    // Async reset mid-operation with count = 3.
    while (mq0.size() > 0) op(0, 1, 0, 8'd0, 8'h00, "drain");
    op(0, 0, 1, 8'd0, 8'h00, "preclr");
    op(1, 0, 0, 8'd2, 8'h42, "rst_e2");
    op(1, 0, 0, 8'd4, 8'h44, "rst_e4");
    op(1, 0, 0, 8'd6, 8'h46, "rst_e6");
    chk("pre-reset count", 32'(count0), 32'd3);
    @(negedge clk);
    enq = 1'b1; kin = 8'd9; vin = 8'h49;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async rst count", 32'(count0), 32'd0);
    chk("async rst kv", {16'b0, kout0, vout0}, 32'd0);
    chk("async rst flags", {27'b0, valid0, full0, empty0, ovf0, unf0}, 32'b00100);
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("in_reset");
    @(negedge clk);
    enq = 1'b0;
    rst_n = 1'b1;
    op(1, 0, 0, 8'd6, 8'h56, "post_rst");
    chk("post_rst count", 32'(count0), 32'd1);
    chk("post_rst head", 32'(kout0), 32'd6);
`ifdef RA_PQ_HWM_EN
    chk("post_rst hwm", 32'(hwm0), 32'd0);
`endif
    op(0, 0, 0, 8'd0, 8'h00, "idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
